// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: pipeline latch enable/flush sequencer with data-wait, redirect, load-use, fetch-miss and halt handling
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_redirect,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       de_rs,
  input  logic [4:0]       de_rt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             fl_en,
  output logic             fl_flush,
  output logic             dl_en,
  output logic             dl_flush,
  output logic             el_en,
  output logic             el_flush,
  output logic             ml_en,
  output logic             ml_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;
  localparam logic [CNT_W-1:0] ONE     = 1;
  localparam logic [8:0]       C_REDIR = 9'b1_01_01_01_10;
  localparam logic [8:0]       C_LU    = 9'b0_00_01_10_10;
  localparam logic [8:0]       C_MISS  = 9'b0_01_10_10_10;
  localparam logic [8:0]       C_RUN   = 9'b1_10_10_10_10;
  state_t           r_state, w_next;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall, r_flush;
  logic [8:0]       w_ctl;
  logic             w_dwait, w_lu, w_live, w_stall_inc, w_flush_inc;
  assign w_dwait = (mem_dREN | mem_dWEN) & ~dhit;
  assign w_lu = ex_MemRead & (ex_wsel != 5'd0) & ((ex_wsel == de_rs) | (ex_wsel == de_rt));
  assign w_live = ~RST & (r_state != HALTED);
  // Next state and prioritised latch controls; RUN and DWAIT share the same output rules.
  always_comb begin
    w_next = (wb_halt || r_state == HALTED) ? HALTED : (w_dwait ? DWAIT : RUN);
    w_ctl = 9'b0;
    if (!w_live || w_dwait) w_ctl = 9'b0;
    else if (mem_redirect) w_ctl = C_REDIR;
    else if (w_lu) w_ctl = C_LU;
    else if (!ihit) w_ctl = C_MISS;
    else w_ctl = C_RUN;
  end
  assign {pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush} = w_ctl;
  assign w_stall_inc = (r_state != HALTED) & ~wb_halt & ~pc_en;
  assign w_flush_inc = (r_state != HALTED) & ~w_dwait & mem_redirect;
  // State, halted flag and saturating performance counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
      r_stall  <= '0;
      r_flush  <= '0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == HALTED);
      if (w_stall_inc && r_stall != '1) r_stall <= r_stall + ONE;
      if (w_flush_inc && r_flush != '1) r_flush <= r_flush + ONE;
    end
  end
  assign halted    = r_halted;
  assign stall_cnt = r_stall;
  assign flush_cnt = r_flush;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks of pipeline_hazard_ctrl against a behavioural model
module tb_pipeline_hazard_ctrl;
  logic       CLK = 1'b0, RST = 1'b1;
  logic       ihit = 1'b1, dhit = 1'b0, mem_dREN = 1'b0, mem_dWEN = 1'b0, mem_redirect = 1'b0;
  logic       ex_MemRead = 1'b0, wb_halt = 1'b0;
  logic [4:0] ex_wsel = '0, de_rs = '0, de_rt = '0;
  logic       pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic       s_pc_en, s_fl_en, s_fl_flush, s_dl_en, s_dl_flush, s_el_en, s_el_flush, s_ml_en, s_ml_flush, s_halted;
  logic [1:0] s_stall_cnt, s_flush_cnt;
  int n_chk = 0, n_fail = 0;
  int m_stall = 0, m_flush = 0;
  bit m_halted = 0;
  wire [8:0] o_vec = {pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush};

  pipeline_hazard_ctrl #(.CNT_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .mem_redirect(mem_redirect), .ex_MemRead(ex_MemRead), .ex_wsel(ex_wsel), .de_rs(de_rs), .de_rt(de_rt),
    .wb_halt(wb_halt), .pc_en(pc_en), .fl_en(fl_en), .fl_flush(fl_flush), .dl_en(dl_en), .dl_flush(dl_flush),
    .el_en(el_en), .el_flush(el_flush), .ml_en(ml_en), .ml_flush(ml_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_hazard_ctrl #(.CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .mem_redirect(mem_redirect), .ex_MemRead(ex_MemRead), .ex_wsel(ex_wsel), .de_rs(de_rs), .de_rt(de_rt),
    .wb_halt(wb_halt), .pc_en(s_pc_en), .fl_en(s_fl_en), .fl_flush(s_fl_flush), .dl_en(s_dl_en), .dl_flush(s_dl_flush),
    .el_en(s_el_en), .el_flush(s_el_flush), .ml_en(s_ml_en), .ml_flush(s_ml_flush), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected control vector {pc, fl_en, fl_fl, dl_en, dl_fl, el_en, el_fl, ml_en, ml_fl} from the rule table.
  function automatic logic [8:0] exp_vec();
    bit dreq_wait = (mem_dREN || mem_dWEN) && !dhit;
    bit lu = ex_MemRead && ex_wsel != 0 && (ex_wsel == de_rs || ex_wsel == de_rt);
    if (RST || m_halted || dreq_wait) return 9'b0_00_00_00_00;
    if (mem_redirect) return 9'b1_01_01_01_10;
    if (lu) return 9'b0_00_01_10_10;
    if (!ihit) return 9'b0_01_10_10_10;
    return 9'b1_10_10_10_10;
  endfunction

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  // Model: halted flag and raw event counts, updated from the pre-edge inputs.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_halted <= 0;
      m_stall  <= 0;
      m_flush  <= 0;
    end else begin
      if (!m_halted && !wb_halt && !exp_vec()[8]) m_stall <= m_stall + 1;
      if (!m_halted && !((mem_dREN || mem_dWEN) && !dhit) && mem_redirect) m_flush <= m_flush + 1;
      if (wb_halt) m_halted <= 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("ctl_vec", {23'd0, o_vec}, {23'd0, exp_vec()});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("stall_cnt", {16'd0, stall_cnt}, sat(m_stall, 16));
    chk("flush_cnt", {16'd0, flush_cnt}, sat(m_flush, 16));
    chk("sat_stall_cnt", {30'd0, s_stall_cnt}, sat(m_stall, 2));
    chk("sat_flush_cnt", {30'd0, s_flush_cnt}, sat(m_flush, 2));
    chk("sat_halted", {31'd0, s_halted}, {31'd0, m_halted});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_redirect = 0;
    ex_MemRead = 0; ex_wsel = 0; de_rs = 0; de_rt = 0; wb_halt = 0;
  endtask

  initial begin
    idle();
    tick(); tick();
    RST = 0; ihit = 0;
    tick(); tick();
    chk("lit_miss_stall2", {16'd0, stall_cnt}, 32'd2);
    ihit = 1;
    #2 RST = 1;
    #1;
    chk("lit_rst_vec", {23'd0, o_vec}, 32'd0);
    chk("lit_rst_stall", {16'd0, stall_cnt}, 32'd0);
    tick();
    RST = 0;
    #1 chk("lit_release_vec", {23'd0, o_vec}, 32'b1_10_10_10_10);
    tick();
    mem_dREN = 1;
    #1 chk("lit_dwait_vec", {23'd0, o_vec}, 32'd0);
    tick(); tick(); tick();
    dhit = 1;
    #1 chk("lit_dwait_done_vec", {23'd0, o_vec}, 32'b1_10_10_10_10);
    tick();
    idle();
    chk("lit_dwait_stall3", {16'd0, stall_cnt}, 32'd3);
    ex_MemRead = 1; ex_wsel = 5; de_rt = 5;
    #1 chk("lit_loaduse_vec", {23'd0, o_vec}, 32'b0_00_01_10_10);
    ex_wsel = 0; de_rt = 0;
    #1 chk("lit_lu_r0_vec", {23'd0, o_vec}, 32'b1_10_10_10_10);
    ex_wsel = 5; de_rt = 5; mem_redirect = 1; ihit = 0;
    #1 chk("lit_redir_lu_vec", {23'd0, o_vec}, 32'b1_01_01_01_10);
    tick();
    chk("lit_flush1", {16'd0, flush_cnt}, 32'd1);
    idle();
    mem_dREN = 1; mem_redirect = 1;
    #1 chk("lit_dwait_redir_vec", {23'd0, o_vec}, 32'd0);
    tick();
    dhit = 1;
    #1 chk("lit_dwait_redir_done", {23'd0, o_vec}, 32'b1_01_01_01_10);
    tick();
    idle();
    wb_halt = 1;
    tick();
    wb_halt = 0;
    chk("lit_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      ihit = i[0];
      #1 chk("lit_halt_vec", {23'd0, o_vec}, 32'd0);
      tick();
    end
    chk("lit_halt_stall_frozen", {16'd0, stall_cnt}, 32'd4);
    #2 RST = 1;
    #1 chk("lit_rst_halted", {31'd0, halted}, 32'd0);
    tick();
    RST = 0; ihit = 0;
    repeat (5) tick();
    chk("lit_sat_stall", {30'd0, s_stall_cnt}, 32'd3);
    tick();
    chk("lit_sat_hold", {30'd0, s_stall_cnt}, 32'd3);
    chk("lit_wide_stall6", {16'd0, stall_cnt}, 32'd6);
    for (int i = 0; i < 3000; i++) begin
      tick();
      RST = ($urandom_range(0, 199) == 0);
      ihit = ($urandom_range(0, 3) != 0);
      dhit = $urandom_range(0, 1) == 1;
      mem_dREN = ($urandom_range(0, 2) == 0);
      mem_dWEN = ($urandom_range(0, 4) == 0);
      mem_redirect = ($urandom_range(0, 5) == 0);
      ex_MemRead = ($urandom_range(0, 2) == 0);
      ex_wsel = 5'($urandom_range(0, 3));
      de_rs = 5'($urandom_range(0, 3));
      de_rt = 5'($urandom_range(0, 3));
      wb_halt = ($urandom_range(0, 299) == 0);
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline. It generates the enable and flush controls for the fetch, decode, execute and memory pipeline latches, plus the PC enable. It resolves three conditions in priority order: data-memory wait, control redirect and load-use hazard. It also handles instruction-fetch misses and processor halt, and keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
ihit  in  1  instruction cache returned a valid instruction this cycle
dhit  in  1  data cache completed the memory-stage access this cycle
mem_dREN  in  1  memory-stage instruction reads data memory
mem_dWEN  in  1  memory-stage instruction writes data memory
mem_redirect  in  1  memory stage resolved a taken branch or jump; PC mux selects the target
ex_MemRead  in  1  execute-stage instruction is a load
ex_wsel  in  5  execute-stage destination register
de_rs  in  5  decode-stage source register rs
de_rt  in  5  decode-stage source register rt
wb_halt  in  1  halt instruction present at the memory-latch output (writeback)
pc_en  out  1  PC register update
fl_en, fl_flush  out  1 each  fetch latch controls
dl_en, dl_flush  out  1 each  decode latch controls
el_en, el_flush  out  1 each  execute latch controls
ml_en, ml_flush  out  1 each  memory latch controls
halted  out  1  processor stopped
stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted
flush_cnt  out  CNT_W  number of redirect flush events

Behaviour:
- State register has three states: RUN, DWAIT, HALTED.
- The enable and flush outputs are combinational from the state and inputs. halted, stall_cnt and flush_cnt are registered.
- Invariant: a latch's flush=1 implies its en=0. A flush and an enable are never both high.
- While RST=1, regardless of clock:
  - state=RUN.
  - All en and flush outputs, pc_en and halted are 0.
  - stall_cnt and flush_cnt are 0.
- Reset asserted mid-stall or mid-halt aborts immediately. The first cycle after deassertion evaluates in RUN.
- Define dreq = mem_dREN | mem_dWEN.
- Define lu_hz = ex_MemRead & (ex_wsel != 0) & (ex_wsel == de_rs | ex_wsel == de_rt).
- Output priority, highest first (RUN and DWAIT states):
  1. HALTED state: all outputs 0; halted=1.
  2. Data wait (dreq & !dhit): all en=0, pc_en=0, no flushes. The whole pipe freezes.
  3. Redirect (mem_redirect, no data wait):
     - pc_en=1, so the target loads even if ihit=0.
     - fl_flush, dl_flush and el_flush = 1.
     - ml_en=1.
  4. Load-use (lu_hz):
     - pc_en=0, fl_en=0 (hold).
     - dl_flush=1, inserting a bubble into execute.
     - el_en=1, ml_en=1.
  5. Fetch miss (!ihit):
     - pc_en=0.
     - fl_flush=1 (bubble).
     - dl_en, el_en, ml_en = 1.
  6. Otherwise: pc_en and all en = 1; no flushes.
- dhit with dreq=0 is ignored. Priorities 3 and 4 apply only when (dreq & !dhit) is false.
- State transitions:
  - RUN -> DWAIT when dreq & !dhit.
  - DWAIT -> RUN on the dhit cycle. In that cycle the pipe advances per priorities 3–6.
  - DWAIT holds while !dhit.
  - Any state -> HALTED when wb_halt=1 at a clock edge, checked before all other conditions. The wb_halt cycle itself still follows the normal priorities, so writeback of the halt completes.
  - HALTED is sticky until RST.
- halted is registered. It rises the cycle after wb_halt is sampled.
- stall_cnt:
  - Increments at each edge where the state is not HALTED, not transitioning to HALTED, and pc_en=0.
  - Saturates at 2^CNT_W-1.
- flush_cnt:
  - Increments at each edge where priority 3 is active.
  - Saturates at 2^CNT_W-1.
- Simultaneous load-use and redirect: redirect wins. The load-use victim is flushed anyway.

Test Plan:
- Reset: assert RST mid-cycle with ihit=1 -> all outputs 0 immediately; after release with ihit=1 and no hazards -> pc_en=1 and every en=1 on the first cycle.
- Data wait: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> all en=0 for 3 cycles (state DWAIT); cycle 4 all en=1; stall_cnt=3.
- Load-use: ex_MemRead=1, ex_wsel=5, de_rt=5 -> pc_en=0, fl_en=0, dl_flush=1, el_en=1, ml_en=1. Repeat with ex_wsel=0 -> no stall.
- Redirect during a load-use hazard, ihit=0 -> pc_en=1, fl/dl/el_flush=1, ml_en=1; flush_cnt increments by 1.
- Data wait combined with mem_redirect=1 and dhit=0 -> full freeze with no flushes; on dhit=1, redirect flushes are applied in that same cycle.
- Halt: wb_halt=1 for one cycle -> halted=1 the next cycle, all controls 0 thereafter despite ihit toggling; stall_cnt frozen; RST clears halted to 0.
- Saturation: run with CNT_W=2 and 5 fetch-miss cycles -> stall_cnt=3 and holds at 3.
